// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD down counter with load, zero and borrow.
// Define BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN for one-shot (stop at zero) mode.
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] d,
    output logic [4*DIGITS-1:0] q,
    output logic                zero,
    output logic                borrow_out
);

    typedef enum logic {
        DIG_IDLE,
        DIG_CHAIN
    } dig_state_e;

    dig_state_e          dstate [DIGITS];
    logic [DIGITS:0]     low_zero;
    logic [4*DIGITS-1:0] q_dec;
    logic [4*DIGITS-1:0] q_load;
    logic                step;

    // A digit is in the borrow chain when every lower digit is zero.
    always_comb begin
        low_zero    = '0;
        low_zero[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dstate[i]     = low_zero[i] ? DIG_CHAIN : DIG_IDLE;
            low_zero[i+1] = low_zero[i] && (q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        q_dec  = q;
        q_load = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dstate[i] == DIG_CHAIN) begin
                q_dec[4*i +: 4] = (q[4*i +: 4] == 4'd0) ?
                                  4'd9 : q[4*i +: 4] - 4'd1;
            end
            q_load[4*i +: 4] = (d[4*i +: 4] > 4'd9) ?
                               4'd9 : d[4*i +: 4];
        end
    end

    assign zero = low_zero[DIGITS];

`ifdef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
    assign step       = en && !zero;
    assign borrow_out = 1'b0;
`else
    assign step       = en;
    assign borrow_out = en && !load && zero;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= q_load;
        end else if (step) begin
            q <= q_dec;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: vector table, corner sequences, cascade and
// randomized checks against an integer reference model.
module tb_bcd_down_counter;

`ifdef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic       zero;
    logic       borrow_out;

    logic       c_en = 1'b0;
    logic       lo_load = 1'b0;
    logic       hi_load = 1'b0;
    logic [3:0] lo_d = 4'h0;
    logic [3:0] hi_d = 4'h0;
    logic [3:0] lo_q, hi_q;
    logic       lo_zero, hi_zero, lo_bo, hi_bo;

    int checks = 0;
    int failures = 0;
    int model = 0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .q(q), .zero(zero), .borrow_out(borrow_out)
    );

    bcd_down_counter #(.DIGITS(1)) u_lo (
        .clk(clk), .reset(reset), .en(c_en), .load(lo_load), .d(lo_d),
        .q(lo_q), .zero(lo_zero), .borrow_out(lo_bo)
    );

    bcd_down_counter #(.DIGITS(1)) u_hi (
        .clk(clk), .reset(reset), .en(lo_bo), .load(hi_load), .d(hi_d),
        .q(hi_q), .zero(hi_zero), .borrow_out(hi_bo)
    );

    typedef struct {
        logic       ld;
        logic       e;
        logic [7:0] dv;
        logic [7:0] exp_q;
        logic       exp_z;
        logic       exp_b;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int load_val(input logic [7:0] dv);
        int t, u;
        t = (dv[7:4] > 4'd9) ? 9 : int'(dv[7:4]);
        u = (dv[3:0] > 4'd9) ? 9 : int'(dv[3:0]);
        return t * 10 + u;
    endfunction

    function automatic int next_val(input int v, input logic ld,
                                    input logic e, input logic [7:0] dv);
        if (ld) return load_val(dv);
        if (!e) return v;
        if (v == 0) return HOLD ? 0 : 99;
        return v - 1;
    endfunction

    // One clock cycle checked against the reference model.
    task automatic mcycle(input string name, input logic ld,
                          input logic e, input logic [7:0] dv);
        @(negedge clk);
        load = ld;
        en   = e;
        d    = dv;
        #1;
        chk({name, ".borrow"}, borrow_out,
            !HOLD && e && !ld && (model == 0));
        @(posedge clk);
        model = next_val(model, ld, e, dv);
        #1;
        chk({name, ".q"}, q, to_bcd(model));
        chk({name, ".zero"}, zero, model == 0);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h09, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h25, 8'h25, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'hAF, 8'h99, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h3C, 8'h39, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h38, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};

        // Reset state, asynchronous, no edge needed.
        #2;
        chk("rst.q", q, 8'h00);
        chk("rst.zero", zero, 1'b1);
        chk("rst.borrow_en0", borrow_out, 1'b0);
        en = 1'b1;
        #1;
        chk("rst.borrow_en1", borrow_out, !HOLD);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            load = vecs[i].ld;
            en   = vecs[i].e;
            d    = vecs[i].dv;
            #1;
            chk($sformatf("vec%0d.borrow", i), borrow_out, vecs[i].exp_b);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.q", i), q, vecs[i].exp_q);
            chk($sformatf("vec%0d.zero", i), zero, vecs[i].exp_z);
        end
        model = 1;

        // Wrap through zero.
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        #1;
        chk("wrap.borrow01", borrow_out, 1'b0);
        @(posedge clk);
        #1;
        chk("wrap.q00", q, 8'h00);
        chk("wrap.zero00", zero, 1'b1);
        @(negedge clk);
        chk("wrap.borrow00", borrow_out, !HOLD);
        @(posedge clk);
        #1;
        chk("wrap.q99", q, HOLD ? 8'h00 : 8'h99);
        chk("wrap.zero99", zero, HOLD);
        model = HOLD ? 0 : 99;

        // Reset asserted mid-count.
        mcycle("ld37", 1'b1, 1'b0, 8'h37);
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst.q", q, 8'h00);
        chk("midrst.zero", zero, 1'b1);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model = 0;
        mcycle("midrst.hold", 1'b0, 1'b0, 8'h00);
        mcycle("midrst.count", 1'b0, 1'b1, 8'h00);

        // Count down to zero and beyond.
        mcycle("os.ld02", 1'b1, 1'b0, 8'h02);
        for (int k = 0; k < 5; k++) mcycle("os.en", 1'b0, 1'b1, 8'h00);
        mcycle("os.ld05", 1'b1, 1'b1, 8'h05);

        // Cascade of two single-digit counters.
        @(negedge clk);
        en = 1'b0;
        load = 1'b0;
        lo_load = 1'b1;
        hi_load = 1'b1;
        lo_d = 4'd0;
        hi_d = 4'd3;
        @(posedge clk);
        #1;
        chk("casc.ld", {hi_q, lo_q}, 8'h30);
        @(negedge clk);
        lo_load = 1'b0;
        hi_load = 1'b0;
        c_en = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("casc.k%0d", k), {hi_q, lo_q},
                HOLD ? 8'h30 : to_bcd((130 - k) % 100));
        end
        @(negedge clk);
        c_en = 1'b0;

        // Randomized against the model.
        for (int n = 0; n < 400; n++) begin
            logic       rl, re;
            logic [7:0] rd;
            rl = ($urandom_range(0, 99) < 12);
            re = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 1) == 1) ?
                 8'($urandom_range(0, 15)) : 8'($urandom);
            mcycle("rand", rl, re, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Synchronous, parameterised multi-digit BCD (decade) down counter with parallel load, count enable, zero flag and cascadable borrow output. Counterpart to the team's decade up counter: counts 9→0 per digit and wraps 0→9 with borrow into the next digit. Used for countdown timers and cycle budgets.

## Interface
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- en  input  1  count enable; decrement by one on a rising edge of clk when 1.
- load  input  1  synchronous parallel load; overrides en.
- d  input  4*DIGITS  BCD load value; digit i is d[4i+3:4i].
- q  output  4*DIGITS  registered BCD count; digit i is q[4i+3:4i].
- zero  output  1  combinational; 1 when every digit of q is 0.
- borrow_out  output  1  combinational; 1 when en=1, load=0 and zero=1, so the next edge wraps. Drives en of a cascaded, more significant counter.

## Operation
- Reset (reset=0): q=0, so zero=1; borrow_out follows its equation (en=1 gives 1). Takes effect without a clock edge and holds while reset=0.
- Priority at each rising clk edge: reset, then load, then en, then hold.
- Load: each digit takes its d digit. Any non-BCD digit (A–F) is stored as 9. The stored value is always legal BCD.
- Decrement, digit 0: n→n−1 for n≥1; 0→9 with a borrow into digit 1.
- Decrement, digit i>0: changes only when all lower digits are 0. It follows the same rule and passes its borrow upward.
- Wrap: all-zero with en=1 goes to all-nines (e.g. 00→99 for DIGITS=2).
- Hold: en=0 and load=0 leaves q unchanged.
- State per digit is idle or borrow-chain. It is evaluated each cycle from the registered value, with no extra state bits.

## Timing
- q changes only on a rising clk edge, or asynchronously on reset assertion.
- Load-to-q latency is 1 cycle. Decrement latency is 1 cycle; the full borrow ripple settles within the same cycle.
- zero and borrow_out are combinational from q, en and load, and are valid in the same cycle as q.
- load and en both 1 in the same cycle: the load wins and no decrement occurs.
- borrow_out is 0 whenever load=1.
- Reset asserted mid-count: q=0 immediately. On release, counting resumes from 0 at the first edge with en=1.
- Reset release must meet recovery/removal to clk. Any deassertion sync is the integrator's responsibility.

## Configuration
- Macro: BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN.
- Defined: one-shot mode.
  - At all-zero, en is ignored and q stays 0 (no wrap).
  - borrow_out is tied to 0.
  - load still works.
- Undefined (default): free-running wrap as described under Operation.

## Test plan
- Reset: drive reset=0 mid-count at q=37 → q=00 and zero=1 before the next clk edge; hold reset=1 with en=0 → q stays 00.
- Load then count (DIGITS=2): load d=0x12, then en=1 for 3 edges → q goes 12, 11, 10, 09; zero=0 throughout.
- Wrap: load 0x01, en=1 → q 01, 00, 99. borrow_out=1 only in the cycle with q=00; zero=1 in that same cycle.
- Load vs enable: q=50, load=1, en=1, d=0x25 → q=25 next edge, not 49; borrow_out=0 while load=1. Load d=0xAF → q=99.
- Cascade: two DIGITS=1 instances, upper.en=lower.borrow_out, lower loaded 0, upper loaded 3, en=1 → pair reads 30, 29, 28; then the full sequence down to 00 and a wrap to 99.
- Macro defined: load 0x02, en=1 for 5 edges → q goes 02, 01, 00, 00, 00; borrow_out=0 throughout. Then load 0x05 → q=05.
